// File: rtl/hc85_seq_cmp.sv
// Sequential, cascadable magnitude comparator: compares SLICE bits per clock MSB-first,
// exits on the first unequal slice and falls back to HC85 cascade inputs when all bits match.
module hc85_seq_cmp #(
  parameter  int WIDTH  = 16,
  parameter  int SLICE  = 4,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int CW     = $clog2(NSLICE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  input  logic             iagb,
  input  logic             iasb,
  input  logic             iaeb,
  output logic             out_valid,
  output logic             qagb,
  output logic             qasb,
  output logic             qaeb,
  output logic [CW-1:0]    nslices_used
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             ig_r, is_r, ie_r;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] sa, sb;
  logic             accept, gt, lt, last, decide;
  logic             r_gt, r_lt, r_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (decide) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand registers shift left each equal slice, so the slice under test is always the top one.
  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_valid && in_ready;
    sa       = a_r[WIDTH-1 -: SLICE];
    sb       = b_r[WIDTH-1 -: SLICE];
    gt       = (sa > sb);
    lt       = (sa < sb);
    last     = (idx == IW'(NSLICE - 1));
    decide   = (state == RUN) && (gt || lt || last);
    if (gt) begin
      r_gt = 1'b1; r_lt = 1'b0; r_eq = 1'b0;
    end else if (lt) begin
      r_gt = 1'b0; r_lt = 1'b1; r_eq = 1'b0;
    end else begin
      r_gt = ~ie_r & ~is_r;
      r_lt = ~ie_r & ~ig_r;
      r_eq = ie_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r          <= '0;
      b_r          <= '0;
      ig_r         <= 1'b0;
      is_r         <= 1'b0;
      ie_r         <= 1'b0;
      idx          <= '0;
      out_valid    <= 1'b0;
      qagb         <= 1'b0;
      qasb         <= 1'b0;
      qaeb         <= 1'b0;
      nslices_used <= '0;
    end else begin
      out_valid <= decide;
      if (accept) begin
        a_r  <= sgn ? (a ^ MSB) : a;
        b_r  <= sgn ? (b ^ MSB) : b;
        ig_r <= iagb;
        is_r <= iasb;
        ie_r <= iaeb;
        idx  <= '0;
      end else if ((state == RUN) && !decide) begin
        a_r <= a_r << SLICE;
        b_r <= b_r << SLICE;
        idx <= idx + IW'(1);
      end
      if (decide) begin
        qagb         <= r_gt;
        qasb         <= r_lt;
        qaeb         <= r_eq;
        nslices_used <= CW'(idx) + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hc85_seq_cmp.sv
// Randomized bench for hc85_seq_cmp: 16/4 and 8/8 instances checked every cycle
// against a transaction-level arithmetic model.
module tb_hc85_seq_cmp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv[2], sg[2], ig[2], is_[2], ie[2];
  logic [15:0] as[2], bs[2];
  logic        ir[2], ov[2], qg[2], ql[2], qe[2];
  logic [2:0]  ns0;
  logic [0:0]  ns1;

  int checks = 0;
  int failures = 0;

  hc85_seq_cmp #(.WIDTH(16), .SLICE(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(as[0]), .b(bs[0]), .sgn(sg[0]), .iagb(ig[0]), .iasb(is_[0]), .iaeb(ie[0]),
    .out_valid(ov[0]), .qagb(qg[0]), .qasb(ql[0]), .qaeb(qe[0]), .nslices_used(ns0));

  hc85_seq_cmp #(.WIDTH(8), .SLICE(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(as[1][7:0]), .b(bs[1][7:0]), .sgn(sg[1]), .iagb(ig[1]), .iasb(is_[1]), .iaeb(ie[1]),
    .out_valid(ov[1]), .qagb(qg[1]), .qasb(ql[1]), .qaeb(qe[1]), .nslices_used(ns1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: compare as integers; latency from the position of the highest differing bit.
  function automatic void ref_cmp(input int w, input int s, input logic [15:0] a, input logic [15:0] b,
                                  input logic sgn, input logic ig_i, input logic is_i, input logic ie_i,
                                  output int k, output logic g, output logic l, output logic e);
    longint am, bm, va, vb, x;
    int p;
    am = longint'(a) & ((64'sd1 <<< w) - 1);
    bm = longint'(b) & ((64'sd1 <<< w) - 1);
    va = am; vb = bm;
    if (sgn && am[w-1]) va = am - (64'sd1 <<< w);
    if (sgn && bm[w-1]) vb = bm - (64'sd1 <<< w);
    if (am == bm) begin
      k = w / s;
      e = ie_i;
      g = !ie_i && !is_i;
      l = !ie_i && !ig_i;
    end else begin
      x = am ^ bm;
      p = 0;
      for (int i = 0; i < w; i++) if (x[i]) p = i;
      k = (w - 1 - p) / s + 1;
      g = va > vb;
      l = va < vb;
      e = 1'b0;
    end
  endfunction

  int   mw[2] = '{16, 8};
  int   msl[2] = '{4, 8};
  logic m_busy[2], m_ov[2], m_g[2], m_l[2], m_e[2];
  logic p_g[2], p_l[2], p_e[2];
  int   m_left[2], m_ns[2], p_k[2];

  always @(posedge clk or posedge rst) begin
    int k;
    logic g, l, e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] <= 1'b0; m_ov[d] <= 1'b0; m_left[d] <= 0;
        m_g[d] <= 1'b0; m_l[d] <= 1'b0; m_e[d] <= 1'b0; m_ns[d] <= 0;
      end else begin
        m_ov[d] <= 1'b0;
        if (!m_busy[d]) begin
          if (iv[d]) begin
            ref_cmp(mw[d], msl[d], as[d], bs[d], sg[d], ig[d], is_[d], ie[d], k, g, l, e);
            m_busy[d] <= 1'b1; m_left[d] <= k; p_k[d] <= k;
            p_g[d] <= g; p_l[d] <= l; p_e[d] <= e;
          end
        end else if (m_left[d] == 1) begin
          m_busy[d] <= 1'b0; m_ov[d] <= 1'b1; m_ns[d] <= p_k[d];
          m_g[d] <= p_g[d]; m_l[d] <= p_l[d]; m_e[d] <= p_e[d];
        end else begin
          m_left[d] <= m_left[d] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready[%0d]", d), int'(ir[d]), int'(!m_busy[d]));
        chk($sformatf("out_valid[%0d]", d), int'(ov[d]), int'(m_ov[d]));
        chk($sformatf("qagb[%0d]", d), int'(qg[d]), int'(m_g[d]));
        chk($sformatf("qasb[%0d]", d), int'(ql[d]), int'(m_l[d]));
        chk($sformatf("qaeb[%0d]", d), int'(qe[d]), int'(m_e[d]));
        chk($sformatf("nslices_used[%0d]", d), (d == 0) ? int'(ns0) : int'(ns1), m_ns[d]);
      end
    end
  end

  task automatic go(input int d, input logic [15:0] a, input logic [15:0] b, input logic s,
                    input logic g, input logic l, input logic e, input bit hold);
    int n;
    @(posedge clk); #1;
    iv[d] = 1'b1; as[d] = a; bs[d] = b; sg[d] = s; ig[d] = g; is_[d] = l; ie[d] = e;
    n = 0;
    forever begin
      @(negedge clk);
      if (ir[d]) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) iv[d] = 1'b0;
  endtask

  task automatic pin(input string name, input int w, input int s, input logic [15:0] a, input logic [15:0] b,
                     input logic sgn, input logic g_i, input logic l_i, input logic e_i,
                     input int ek, input logic eg, input logic el, input logic ee);
    int k; logic g, l, e;
    ref_cmp(w, s, a, b, sgn, g_i, l_i, e_i, k, g, l, e);
    chk({name, "_k"}, k, ek);
    chk({name, "_res"}, int'({g, l, e}), int'({eg, el, ee}));
  endtask

  initial begin
    int sel;
    logic [15:0] ra, rb;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; as[d] = 0; bs[d] = 0; sg[d] = 0; ig[d] = 0; is_[d] = 0; ie[d] = 0;
    end

    pin("m_lowslice", 16, 4, 16'h1234, 16'h1233, 0, 0, 0, 0, 4, 1, 0, 0);
    pin("m_uns_msb", 16, 4, 16'h8000, 16'h7FFF, 0, 0, 0, 0, 1, 1, 0, 0);
    pin("m_sgn_msb", 16, 4, 16'h8000, 16'h7FFF, 1, 0, 0, 0, 1, 0, 1, 0);
    pin("m_casc_eq", 16, 4, 16'hBEEF, 16'hBEEF, 0, 0, 0, 1, 4, 0, 0, 1);
    pin("m_casc_000", 16, 4, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0, 4, 1, 1, 0);
    pin("m_casc_gt", 16, 4, 16'hBEEF, 16'hBEEF, 0, 1, 0, 0, 4, 1, 0, 0);
    pin("m_casc_11", 16, 4, 16'hBEEF, 16'hBEEF, 0, 1, 1, 0, 4, 0, 0, 0);
    pin("m_b2b1", 16, 4, 16'h00F0, 16'h0F00, 0, 0, 0, 0, 2, 0, 1, 0);
    pin("m_single", 8, 8, 16'h007F, 16'h0080, 1, 0, 0, 0, 1, 1, 0, 0);

    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_out", int'({ov[0], qg[0], ql[0], qe[0], ns0}), 0);
    #9 rst = 1'b0;

    go(0, 16'h1234, 16'h1233, 0, 0, 0, 0, 0);
    go(0, 16'h8000, 16'h7FFF, 0, 0, 0, 0, 0);
    go(0, 16'h8000, 16'h7FFF, 1, 0, 0, 0, 0);
    go(0, 16'hBEEF, 16'hBEEF, 0, 0, 0, 1, 0);
    go(0, 16'hBEEF, 16'hBEEF, 0, 0, 0, 0, 0);
    go(0, 16'hBEEF, 16'hBEEF, 0, 1, 0, 0, 0);
    go(0, 16'hBEEF, 16'hBEEF, 0, 1, 1, 0, 0);
    go(0, 16'h00F0, 16'h0F00, 0, 0, 0, 0, 1);
    go(0, 16'h0001, 16'h0001, 0, 0, 0, 1, 0);
    go(1, 16'h007F, 16'h0080, 1, 0, 0, 0, 0);
    repeat (6) @(posedge clk);

    go(0, 16'hBEEF, 16'hBEEF, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(ir[0]), 1);
    chk("midrst_out", int'({ov[0], qg[0], ql[0], qe[0], ns0}), 0);
    @(negedge clk); #3 rst = 1'b0;
    repeat (6) @(posedge clk);

    for (int t = 0; t < 400; t++) begin
      sel = $urandom_range(0, 2);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (sel == 1) rb = ra;
      else if (sel == 2) rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      if (t >= 300) begin
        if (sel == 1) rb = ra;
        go(1, {8'h00, ra[7:0]}, {8'h00, rb[7:0]}, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0));
      end else begin
        go(0, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    #1 iv[0] = 1'b0; iv[1] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
